// File: rtl/nto1_stream_mux_pkg.sv
// Shared types and helpers for the N:1 stream multiplexer and related arbiters.
package nto1_stream_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int MAX_N  = 16;
    localparam int MAX_SW = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // One-hot grant to the first valid channel above 'last', wrapping modulo n.
    function automatic logic [MAX_N-1:0] rr_next(
        input logic [MAX_N-1:0]  valid,
        input logic [MAX_SW-1:0] last,
        input int                n
    );
        logic [MAX_N-1:0]  grant;
        logic [MAX_SW-1:0] idx;
        grant = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            idx = MAX_SW'((int'(last) + k) % n);
            if (k <= n && grant == '0 && valid[idx]) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/nto1_stream_mux_rr_arbiter.sv
// Rotating-priority arbiter: grants the first valid channel after last_grant.
module rr_arbiter
    import nto1_stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] last_grant,
    output logic [N-1:0]  grant
);

    logic [MAX_N-1:0] full_grant;
    logic             unused_hi;

    always_comb begin
        full_grant = rr_next(MAX_N'(valid), MAX_SW'(last_grant), N);
        grant      = full_grant[N-1:0];
    end

    // Bits above N can never be set; fold them away explicitly.
    generate
        if (N < MAX_N) begin : g_pad
            assign unused_hi = |full_grant[MAX_N-1:N];
        end else begin : g_nopad
            assign unused_hi = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/nto1_stream_mux.sv
// N-input registered stream multiplexer with manual-select or round-robin arbitration.
// valid/ready: a word moves on a port at a rising edge where both valid and ready are high.
module nto1_stream_mux
    import nto1_stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    input  logic           out_ready
);

    state_t        state_q, state_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_chan_q, out_chan_d;
    logic [SW-1:0] last_grant_q, last_grant_d;

    logic          load_en;
    logic [N-1:0]  rr_grant;
    logic [N-1:0]  man_grant;
    logic [N-1:0]  grant;
    logic          take;
    logic [SW-1:0] take_chan;
    logic [W-1:0]  take_data;

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .valid      (in_valid),
        .last_grant (last_grant_q),
        .grant      (rr_grant)
    );

    always_comb begin
        man_grant = '0;
        // sel may exceed N-1 when N is not a power of two; such a select grants nothing.
        if (int'(sel) < N) begin
            man_grant[sel] = in_valid[sel];
        end
        grant     = (mode == MODE_RR) ? rr_grant : man_grant;
        load_en   = (state_q == ST_EMPTY) || out_ready;
        in_ready  = load_en ? grant : '0;
        take      = |in_ready;
        take_chan = '0;
        take_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                take_chan = SW'(i);
                take_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        last_grant_d = last_grant_q;
        if (take) begin
            state_d    = ST_FULL;
            out_data_d = take_data;
            out_chan_d = take_chan;
            if (mode == MODE_RR) begin
                last_grant_d = take_chan;
            end
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            last_grant_q <= SW'(N - 1);
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_nto1_stream_mux.sv
// Randomized and directed bench for nto1_stream_mux against a transaction-level reference model.
module tb_nto1_stream_mux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_ready;

    logic           mode3;
    logic [1:0]     sel3;
    logic [2:0]     in_valid3;
    logic [3*W-1:0] in_data3;
    logic [2:0]     in_ready3;
    logic           out_valid3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_chan3;
    logic           out_ready3;

    nto1_stream_mux #(.N(N), .W(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    nto1_stream_mux #(.N(3), .W(W)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_ready (out_ready3)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: one held word plus the round-robin pointer
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_last;
    logic [N-1:0] last_acc;
    logic [SW+W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_chan   = 0;
        m_last   = N - 1;
        last_acc = '0;
        exp_q.delete();
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] g;
        logic         found;
        int           idx;
        g     = '0;
        found = 1'b0;
        if (m_valid && !out_ready) return '0;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) g[sel] = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && in_valid[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // One clock: check outputs against the model, advance the model, end at next negedge.
    task automatic cycle();
        logic [N-1:0]    er;
        logic [SW+W-1:0] item;
        #1;
        er = model_ready();
        check("in_ready", 32'(in_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_chan", 32'(out_chan), 32'(m_chan));
        end
        if (m_valid && out_ready) begin
            check("sb_size", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                check("sb_word", 32'({out_chan, out_data}), 32'(item));
            end
            m_valid = 1'b0;
        end
        last_acc = er & in_valid;
        for (int ch = 0; ch < N; ch++) begin
            if (last_acc[ch]) begin
                m_valid = 1'b1;
                m_data  = in_data[ch*W +: W];
                m_chan  = ch;
                if (mode) m_last = ch;
                exp_q.push_back({SW'(ch), m_data});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    int fair_seq[5] = '{0, 1, 2, 3, 0};
    int skip_seq[4] = '{1, 3, 1, 3};
    logic [W-1:0] held_data;
    logic [SW-1:0] held_chan;

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b0;
        sel        = '0;
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        mode3      = 1'b0;
        sel3       = 2'd3;
        in_valid3  = '0;
        in_data3   = '0;
        out_ready3 = 1'b1;
        model_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // out-of-range select on the 3-channel instance
        in_valid3 = 3'b111;
        in_data3  = 24'h33_22_11;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("oor_in_ready", 32'(in_ready3), 32'd0);
            check("oor_out_valid", 32'(out_valid3), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        sel3 = 2'd1;
        #1;
        check("n3_in_ready", 32'(in_ready3), 32'b010);
        @(posedge clk);
        @(negedge clk);
        check("n3_out_valid", 32'(out_valid3), 32'd1);
        check("n3_out_chan", 32'(out_chan3), 32'd1);
        check("n3_out_data", 32'(out_data3), 32'h22);

        // randomized traffic; producers hold their word until it is accepted
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
            sel       = SW'($urandom_range(0, N - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!(in_valid[i] && !last_acc[i])) begin
                    in_valid[i]        = ($urandom_range(0, 2) != 0);
                    in_data[i*W +: W]  = W'($urandom);
                end
            end
            cycle();
        end

        // reset in the middle of traffic
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_out_chan", 32'(out_chan), 32'd0);
        model_reset();
        mode      = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h44_33_22_11;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // round-robin fairness, channel 0 first after reset
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_fair_seq", 32'(out_chan), 32'(fair_seq[i]));
        end

        // round-robin skipping idle channels
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_skip_seq", 32'(out_chan), 32'(skip_seq[i]));
        end

        // manual select
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        in_data  = 32'h00_A5_00_00;
        #1;
        check("man_in_ready", 32'(in_ready), 32'b0100);
        cycle();
        check("man_out_data", 32'(out_data), 32'hA5);
        check("man_out_chan", 32'(out_chan), 32'd2);

        // backpressure with a word held
        held_data = out_data;
        held_chan = out_chan;
        mode      = 1'b1;
        in_valid  = 4'b0001;
        in_data   = 32'h00_00_00_3C;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_data_stable", 32'(out_data), 32'(held_data));
            check("bp_chan_stable", 32'(out_chan), 32'(held_chan));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_valid", 32'(out_valid), 32'd1);
        check("bp_release_chan", 32'(out_chan), 32'd0);
        check("bp_release_data", 32'(out_data), 32'h3C);
        in_valid = '0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
